// File: rtl/arbiter_pkg.sv
// Shared definitions for the round-robin timeout arbiter.
//   FLIT_HEADER / FLIT_BODY / FLIT_TAIL : per-port flit type encodings
//   arb_state_e                         : arbiter state (idle or holding a grant)
package arbiter_pkg;

  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_port_timer.sv
// Per-port packet timer: latches the packet length from header flits and
// counts the cycles the port's current grant has been held.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   run       : port currently holds the grant
//   restart   : port is (re)granted at the coming edge; counter returns to 0
//   header    : header flit with request on this port; latch length
//   length    : packet length carried by the header flit
//   timesup   : last allowed cycle of the current grant (len_q == 0 disables)
module arb_port_timer #(
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             restart,
  input  logic             header,
  input  logic [LEN_W-1:0] length,
  output logic             timesup
);

  localparam logic [LEN_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      cnt   <= '0;
    end else begin
      // A header mid-grant only changes the limit; the running count is kept.
      if (header) len_q <= length;
      if (restart) begin
        cnt <= '0;
      end else if (run && (cnt != CNT_MAX)) begin
        // Saturate so an unlimited grant (len_q == 0) never wraps.
        cnt <= cnt + ONE;
      end
    end
  end

  // Expire on cycle len_q-1 so the grant lasts exactly len_q cycles.
  assign timesup = run && (len_q != '0) && (cnt == (len_q - ONE));

endmodule

// File: rtl/rr_timeout_arbiter.sv
// N-port round-robin arbiter with per-port packet timeout (router output stage).
// Holds a grant while the owner requests, for at most the packet length latched
// from that port's header flit; the next owner is chosen round-robin with the
// previous owner checked last, registered in the same cycle as the release.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req          : per-port request
//   flit_id      : per-port flit type, port i at [i*FLIT_ID_W +: FLIT_ID_W]
//   length       : per-port packet length, sampled on header flits
//   grant        : registered one-hot grant, all-zero when idle
//   grant_id     : binary index of the granted port (valid with grant_valid)
//   grant_valid  : |grant
//   timeout      : one-cycle pulse when a grant is revoked by timer expiry
// Optional feature: define ARB_TAIL_RELEASE_EN to also release the grant on a
// tail flit from the owner (no timeout pulse in that case).
module rr_timeout_arbiter
  import arbiter_pkg::*;
#(
  parameter int N_PORTS   = 5,
  parameter int LEN_W     = 12,
  parameter int FLIT_ID_W = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PORTS-1:0]           req,
  input  logic [N_PORTS*FLIT_ID_W-1:0] flit_id,
  input  logic [N_PORTS*LEN_W-1:0]     length,
  output logic [N_PORTS-1:0]           grant,
  output logic [$clog2(N_PORTS)-1:0]   grant_id,
  output logic                         grant_valid,
  output logic                         timeout
);

  localparam int ID_W = $clog2(N_PORTS);

  arb_state_e        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [N_PORTS-1:0] timesup;
  logic [N_PORTS-1:0] tail_vec;
  logic [N_PORTS-1:0] restart;

  logic            release_now;
  logic            expiry;
  logic            load;
  logic            found;
  logic [ID_W-1:0] next_idx;
  logic [ID_W-1:0] base;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    logic hdr;
    assign hdr = req[i] &&
                 (flit_id[i*FLIT_ID_W +: FLIT_ID_W] == FLIT_ID_W'(FLIT_HEADER));

    arb_port_timer #(
      .LEN_W(LEN_W)
    ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .run     (grant[i]),
      .restart (restart[i]),
      .header  (hdr),
      .length  (length[i*LEN_W +: LEN_W]),
      .timesup (timesup[i])
    );

`ifdef ARB_TAIL_RELEASE_EN
    assign tail_vec[i] = req[i] &&
                         (flit_id[i*FLIT_ID_W +: FLIT_ID_W] == FLIT_ID_W'(FLIT_TAIL));
`else
    assign tail_vec[i] = 1'b0;
`endif
  end

  always_comb begin
    release_now = 1'b0;
    expiry      = 1'b0;
    if (state == ARB_GRANT) begin
      release_now = !req[grant_id] || timesup[grant_id] || tail_vec[grant_id];
      // Only a grant the owner still wants counts as revoked by the timer.
      expiry      = timesup[grant_id] && req[grant_id] && !tail_vec[grant_id];
    end

    // Search starts after the current owner (or rr_ptr when idle), so the
    // owner itself is the last candidate.
    base     = (state == ARB_IDLE) ? rr_ptr : grant_id;
    found    = 1'b0;
    next_idx = '0;
    for (int off = 1; off <= N_PORTS; off++) begin
      int idx;
      idx = int'(base) + off;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!found && req[idx]) begin
        found    = 1'b1;
        next_idx = ID_W'(idx);
      end
    end

    load    = (state == ARB_IDLE) || release_now;
    restart = '0;
    if (load && found) restart[next_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      grant_id <= '0;
      rr_ptr   <= ID_W'(N_PORTS - 1);
      timeout  <= 1'b0;
    end else begin
      timeout <= expiry;
      if (load) begin
        if (found) begin
          state    <= ARB_GRANT;
          grant    <= restart;
          grant_id <= next_idx;
          rr_ptr   <= next_idx;
        end else begin
          state    <= ARB_IDLE;
          grant    <= '0;
          grant_id <= '0;
        end
      end
    end
  end

  assign grant_valid = |grant;

endmodule
